// File: rtl/mux16_pkg.sv
// Shared constants, state encoding and round-robin search for the 16:1 mux arbiter.
package mux16_pkg;

    localparam int N_IN  = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Beat counter width; a MAX_BEATS of 0 or 1 still needs one bit.
    function automatic int cnt_width(input int max_beats);
        return (max_beats > 1) ? $clog2(max_beats) : 1;
    endfunction

    // First set request at or above ptr, wrapping 15 -> 0. Walking k downwards
    // lets the smallest offset from ptr overwrite any later candidates.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_IN-1:0]  req,
                                                 input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] idx;
        logic [SEL_W-1:0] win;
        win = ptr;
        for (int k = N_IN - 1; k >= 0; k--) begin
            idx = ptr + SEL_W'(k);
            if (req[idx]) begin
                win = idx;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/mux_16to1.sv
// Single-bit 16:1 multiplexer datapath shared by all requesters.
module mux_16to1 (
    input  logic [15:0] d_i,
    input  logic [3:0]  s_i,
    output logic        y_o
);

    assign y_o = d_i[s_i];

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter that owns the 16:1 mux select and presents the chosen bit
// downstream over a valid/ready handshake, with optional per-grant beat limit.
module mux16_rr_arbiter
    import mux16_pkg::*;
#(
    parameter int MAX_BEATS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic [15:0] din,
    input  logic        out_ready,
    output logic [15:0] gnt,
    output logic [3:0]  sel,
    output logic        out_valid,
    output logic        out_data,
    output logic        busy
);

    localparam int                CNT_W    = cnt_width(MAX_BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0]    gnt_q, gnt_d;
    logic               vld_q, vld_d;

    logic               beat;
    logic               last_beat;
    logic               release_now;
    logic [N_IN-1:0]    others;
    logic [SEL_W-1:0]   ptr_next;
    logic               mux_y;

    assign beat        = (state_q == GRANT) && out_ready;
    assign last_beat   = (MAX_BEATS != 0) && beat && (cnt_q == CNT_LAST);
    assign release_now = !req[sel_q] || last_beat;
    assign others      = req & ~(N_IN'(1) << sel_q);
    assign ptr_next    = sel_q + SEL_W'(1);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    sel_d   = rr_pick(req, ptr_q);
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    // The released requester is masked out, so a lone holder
                    // passes through IDLE before it is granted again.
                    ptr_d = ptr_next;
                    cnt_d = '0;
                    if (|others) begin
                        sel_d = rr_pick(others, ptr_next);
                    end else begin
                        state_d = IDLE;
                        sel_d   = '0;
                    end
                end else if (beat) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
            end
        endcase
    end

    assign vld_d = (state_d == GRANT);
    assign gnt_d = vld_d ? (N_IN'(1) << sel_d) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            vld_q   <= vld_d;
        end
    end

    mux_16to1 u_mux (
        .d_i (din),
        .s_i (sel_q),
        .y_o (mux_y)
    );

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign out_valid = vld_q;
    assign busy      = (state_q == GRANT);
    assign out_data  = vld_q & mux_y;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Randomized and directed bench for mux16_rr_arbiter against a queue-free
// behavioural model of the round-robin grant rules.
module tb_mux16_rr_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic [15:0] din = '0;
    logic        out_ready = 1'b0;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        out_valid;
    logic        out_data;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit m_act;
    int m_w;
    int m_ptr;
    int m_cnt;

    mux16_rr_arbiter #(.MAX_BEATS(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .din       (din),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [15:0] r, input int from);
        for (int k = 0; k < 16; k++) begin
            if (r[(from + k) % 16]) return (from + k) % 16;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_act = 0; m_w = 0; m_ptr = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input logic [15:0] r, input logic rdy);
        logic [15:0] oth;
        bit          rel;
        if (!m_act) begin
            if (r != 0) begin
                m_act = 1;
                m_w   = pick(r, m_ptr);
                m_cnt = 0;
            end
        end else begin
            rel = !r[m_w] || (MB != 0 && rdy && m_cnt == MB - 1);
            if (rel) begin
                m_ptr = (m_w + 1) % 16;
                m_cnt = 0;
                oth   = r;
                oth[m_w] = 1'b0;
                if (oth != 0) m_w = pick(oth, m_ptr);
                else          m_act = 0;
            end else if (rdy) begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_all();
        logic [15:0] eg;
        eg = m_act ? (16'h1 << m_w) : 16'h0;
        chk("gnt", gnt, eg);
        chk("valid", out_valid, m_act);
        chk("busy", busy, m_act);
        if (m_act) chk("sel", sel, m_w);
        chk("data", out_data, m_act ? din[m_w] : 1'b0);
    endtask

    task automatic step(input logic [15:0] r, input logic [15:0] d, input logic rdy);
        req = r; din = d; out_ready = rdy;
        #1;
        chk("data_live", out_data, m_act ? d[m_w] : 1'b0);
        @(posedge clk);
        model_edge(r, rdy);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        chk("rst_gnt", gnt, 16'h0);
        chk("rst_sel", sel, 4'h0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", out_data, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int          exp_sel[10];
        logic [15:0] r;
        exp_sel = '{0, 0, 0, 0, 15, 15, 15, 15, 0, 0};

        // Reset while every input requests
        req = 16'hFFFF; din = 16'h0; out_ready = 1'b1;
        #3;
        do_reset();
        step(16'hFFFF, 16'h0, 1'b0);
        chk("t1_gnt", gnt, 16'h0001);
        chk("t1_sel", sel, 4'h0);

        // Rotation with wrap between inputs 0 and 15
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(16'h8001, 16'h8001, 1'b1);
            chk("t2_sel", sel, exp_sel[i]);
        end

        // Live data through the mux while stalled
        do_reset();
        step(16'h0010, 16'h0010, 1'b0);
        chk("t3_d1", out_data, 1'b1);
        step(16'h0010, 16'h0000, 1'b0);
        chk("t3_d0", out_data, 1'b0);
        chk("t3_gnt", gnt, 16'h0010);

        // Withdraw while stalled, pointer moves to 10
        do_reset();
        step(16'h0200, 16'h0, 1'b0);
        step(16'h0000, 16'h0, 1'b0);
        chk("t4_gnt", gnt, 16'h0);
        chk("t4_valid", out_valid, 1'b0);
        step(16'hFFFF, 16'h0, 1'b0);
        chk("t4_ptr", gnt, 16'h0400);

        // Backpressure does not advance the beat count
        do_reset();
        step(16'h0004, 16'hFFFF, 1'b0);
        step(16'h0004, 16'hFFFF, 1'b1);
        step(16'h0004, 16'hFFFF, 1'b0);
        step(16'h0004, 16'hFFFF, 1'b0);
        step(16'h0004, 16'hFFFF, 1'b1);
        step(16'h0004, 16'hFFFF, 1'b1);
        chk("t5_hold", gnt, 16'h0004);
        step(16'h0004, 16'hFFFF, 1'b1);
        chk("t5_rel", gnt, 16'h0000);
        step(16'h0004, 16'hFFFF, 1'b1);
        chk("t5_regrant", gnt, 16'h0004);

        // Asynchronous reset mid-grant
        do_reset();
        step(16'h0080, 16'hFFFF, 1'b1);
        step(16'h0080, 16'hFFFF, 1'b1);
        step(16'h0080, 16'hFFFF, 1'b1);
        #2;
        do_reset();
        step(16'hFFFF, 16'h0, 1'b1);
        chk("t6_gnt", gnt, 16'h0001);

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0:       r = 16'h1 << $urandom_range(0, 15);
                1:       r = 16'($urandom) & 16'($urandom) & 16'($urandom);
                2:       r = m_act && $urandom_range(0, 3) != 0 ? (16'h1 << m_w) | (16'h1 << $urandom_range(0, 15)) : 16'h0;
                default: r = 16'($urandom);
            endcase
            if ($urandom_range(0, 199) == 0) begin
                #2;
                do_reset();
            end
            step(r, 16'($urandom), 1'($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
